// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one memory port between the CPU and a secondary master (port B)
// Port B is served by holding the CPU, draining its in-flight reads, then issuing one B access.
module rv32i_mem_arbiter #(
   parameter int MEM_LATENCY    = 1,
   parameter int MIN_CPU_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_wr_mask,
   output logic [31:0] cpu_rdata,
   output logic        cpu_hold,
   input  logic        b_req,
   input  logic        b_wr,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   input  logic [3:0]  b_wr_mask,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wr_mask,
   input  logic [31:0] mem_rdata
);
   localparam int CW = $clog2(MIN_CPU_CYCLES + 2);
   typedef enum logic [1:0] {S_CPU, S_DRAIN, S_ISSUE, S_WAIT} state_t;
   state_t state_q, state_d;
   logic                   cpu_hold_q, cpu_hold_d;
   logic [CW-1:0]          cpu_cnt_q, cpu_cnt_d;
   logic [1:0]             drain_cnt_q, drain_cnt_d;
   logic                   b_wr_q, b_wr_d;
   logic [MEM_LATENCY-1:0] cpu_pipe_q, cpu_pipe_d, b_pipe_q, b_pipe_d;
   logic [31:0]            cpu_data_q, cpu_data_d, b_data_q, b_data_d;
   logic                   fwd, issue, cpu_ret, b_ret;
   always_comb begin
      fwd         = state_q == S_CPU || state_q == S_DRAIN;
      issue       = state_q == S_ISSUE;
      mem_rd      = fwd ? cpu_rd & ~cpu_wr : issue & ~b_wr;
      mem_wr      = fwd ? cpu_wr : issue & b_wr;
      mem_addr    = fwd ? cpu_addr : b_addr;
      mem_wdata   = fwd ? cpu_wdata : b_wdata;
      mem_wr_mask = fwd ? cpu_wr_mask : issue ? b_wr_mask : 4'b0;
      cpu_ret     = cpu_pipe_q[MEM_LATENCY-1];
      b_ret       = b_pipe_q[MEM_LATENCY-1];
      // returning data bypasses the capture register so neither master sees extra latency
      cpu_rdata   = cpu_ret ? mem_rdata : cpu_data_q;
      b_rdata     = b_ret ? mem_rdata : b_data_q;
      b_ack       = state_q == S_WAIT && (b_wr_q || b_ret);
      cpu_hold    = cpu_hold_q;
   end
   always_comb begin
      state_d     = state_q;
      cpu_hold_d  = cpu_hold_q;
      cpu_cnt_d   = cpu_cnt_q;
      drain_cnt_d = drain_cnt_q;
      b_wr_d      = b_wr_q;
      cpu_pipe_d  = (cpu_pipe_q << 1) | MEM_LATENCY'(fwd & cpu_rd & ~cpu_wr);
      b_pipe_d    = (b_pipe_q << 1) | MEM_LATENCY'(issue & ~b_wr);
      cpu_data_d  = cpu_rdata;
      b_data_d    = b_rdata;
      case (state_q)
         S_CPU: begin
            cpu_cnt_d = cpu_cnt_q == CW'(MIN_CPU_CYCLES) ? cpu_cnt_q : cpu_cnt_q + 1'b1;
            if (b_req && cpu_cnt_q == CW'(MIN_CPU_CYCLES)) begin
               state_d     = S_DRAIN;
               cpu_hold_d  = 1'b1;
               drain_cnt_d = 2'd0;
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + 2'd1;
            state_d     = drain_cnt_q == 2'(MEM_LATENCY) ? S_ISSUE : S_DRAIN;
         end
         S_ISSUE: begin
            b_wr_d  = b_wr;
            state_d = S_WAIT;
         end
         default: begin
            if (b_ack) begin
               state_d    = S_CPU;
               cpu_hold_d = 1'b0;
               cpu_cnt_d  = '0;
            end
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_CPU;
         cpu_hold_q  <= 1'b0;
         cpu_cnt_q   <= CW'(MIN_CPU_CYCLES);
         drain_cnt_q <= 2'd0;
         b_wr_q      <= 1'b0;
         cpu_pipe_q  <= '0;
         b_pipe_q    <= '0;
         cpu_data_q  <= '0;
         b_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         cpu_hold_q  <= cpu_hold_d;
         cpu_cnt_q   <= cpu_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         b_wr_q      <= b_wr_d;
         cpu_pipe_q  <= cpu_pipe_d;
         b_pipe_q    <= b_pipe_d;
         cpu_data_q  <= cpu_data_d;
         b_data_q    <= b_data_d;
      end
   end
endmodule
